// File: rtl/pam5_symbol_mapper.sv
// Byte-stream to 4-lane scrambled PAM5 symbol mapper with SSD/ESD framing and idle fill, feeding the FFE.
// Optional scrambler test-pattern mode is built when PAM5_MAPPER_PRBS_EN is defined (adds port io_prbs).
module pam5_symbol_mapper #(
   parameter int unsigned LEVEL = 32,
   parameter logic [32:0] SEED  = 33'h1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       io_en,
`ifdef PAM5_MAPPER_PRBS_EN
   input  logic       io_prbs,
`endif
   input  logic       io_in_valid,
   output logic       io_in_ready,
   input  logic [7:0] io_in_bits,
   input  logic       io_in_last,
   output logic       io_out_valid,
   output logic [7:0] io_out_bits_0,
   output logic [7:0] io_out_bits_1,
   output logic [7:0] io_out_bits_2,
   output logic [7:0] io_out_bits_3,
   output logic       io_underrun
);

   localparam int unsigned SYM_W = 8;
   localparam int unsigned LANES = 4;
   localparam int unsigned SCR_W = 33;

   // Level constants are formed at 9 bits signed, then truncated to the 8-bit lane width.
   localparam logic [SYM_W-1:0] SYM_P2 = SYM_W'(9'(2 * LEVEL));
   localparam logic [SYM_W-1:0] SYM_P1 = SYM_W'(9'(LEVEL));
   localparam logic [SYM_W-1:0] SYM_M1 = SYM_W'(9'(0) - 9'(LEVEL));
   localparam logic [SYM_W-1:0] SYM_M2 = SYM_W'(9'(0) - 9'(2 * LEVEL));

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SSD1 = 3'd1,
      ST_SSD2 = 3'd2,
      ST_DATA = 3'd3,
      ST_ESD1 = 3'd4,
      ST_ESD2 = 3'd5
   } state_t;

   state_t                         state_q, state_d;
   logic [SCR_W-1:0]               scr_q, scr_d;
   logic                           valid_q, valid_d;
   logic                           under_q, under_d;
   logic [LANES-1:0][SYM_W-1:0]    lane_q, lane_d;
   logic [LANES-1:0][SYM_W-1:0]    idle_lanes, data_lanes;
   logic [7:0]                     dbyte;
   logic                           prbs_act;

   function automatic logic [SYM_W-1:0] gray_sym(input logic [1:0] b);
      case (b)
         2'b00:   return SYM_M2;
         2'b01:   return SYM_M1;
         2'b11:   return SYM_P1;
         default: return SYM_P2;
      endcase
   endfunction

`ifdef PAM5_MAPPER_PRBS_EN
   assign prbs_act = io_prbs;
`else
   assign prbs_act = 1'b0;
`endif

   assign io_in_ready = (state_q == ST_DATA) && io_en && !prbs_act;

   // Candidate lane values from the current (pre-advance) scrambler byte.
   always_comb begin
      dbyte = io_in_bits ^ scr_q[7:0];
      for (int k = 0; k < LANES; k++) begin
         idle_lanes[k] = scr_q[2*k] ? SYM_P2 : SYM_M2;
         data_lanes[k] = gray_sym(dbyte[2*k +: 2]);
      end
   end

   always_comb begin
      state_d = state_q;
      scr_d   = scr_q;
      valid_d = io_en;
      under_d = under_q;
      lane_d  = '0;
      if (!io_en) begin
         state_d = ST_IDLE;
      end else begin
         scr_d = {scr_q[SCR_W-2:0], scr_q[SCR_W-1] ^ scr_q[12]};
         if (prbs_act) begin
            state_d = ST_IDLE;
            lane_d  = idle_lanes;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  lane_d = idle_lanes;
                  if (io_in_valid) state_d = ST_SSD1;
               end
               ST_SSD1: begin
                  lane_d  = {LANES{SYM_P2}};
                  state_d = ST_SSD2;
               end
               ST_SSD2: begin
                  lane_d  = {LANES{SYM_P2}};
                  state_d = ST_DATA;
               end
               ST_DATA: begin
                  // A missing byte inside a packet sends zero symbols and is flagged permanently.
                  if (io_in_valid) begin
                     lane_d = data_lanes;
                     if (io_in_last) state_d = ST_ESD1;
                  end else begin
                     under_d = 1'b1;
                  end
               end
               ST_ESD1: begin
                  lane_d  = {LANES{SYM_M2}};
                  state_d = ST_ESD2;
               end
               ST_ESD2: begin
                  lane_d  = {LANES{SYM_M2}};
                  state_d = ST_IDLE;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         scr_q   <= SEED;
         valid_q <= 1'b0;
         under_q <= 1'b0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         scr_q   <= scr_d;
         valid_q <= valid_d;
         under_q <= under_d;
         lane_q  <= lane_d;
      end
   end

   assign io_out_valid  = valid_q;
   assign io_underrun   = under_q;
   assign io_out_bits_0 = lane_q[0];
   assign io_out_bits_1 = lane_q[1];
   assign io_out_bits_2 = lane_q[2];
   assign io_out_bits_3 = lane_q[3];

endmodule

// File: tb/tb_pam5_symbol_mapper.sv
// Self-checking bench for pam5_symbol_mapper: two instances (SEED=1 and SEED=0) share stimulus
// and are compared against a packet-schedule reference model plus directed known values.
module tb_pam5_symbol_mapper;
   localparam int LEVEL = 32;

   typedef enum int {K_SSD, K_DATA, K_ESD} kind_e;

   logic            clock = 1'b0;
   logic            reset;
   logic            io_en;
   logic            io_in_valid;
   logic            io_in_last;
   logic [7:0]      io_in_bits;
   logic            rdy1, rdy0, ov1, ov0, un1, un0;
   logic [3:0][7:0] o1, o0;

   kind_e           sched[$];
   logic [32:0]     m_scr1, m_scr0;
   logic [3:0][7:0] e1, e0;
   logic            e_valid, e_under;
   int              checks = 0;
   int              errors = 0;

   always #5 clock = ~clock;

   pam5_symbol_mapper #(.LEVEL(LEVEL), .SEED(33'h1)) u_dut1 (
      .clock(clock), .reset(reset), .io_en(io_en),
`ifdef PAM5_MAPPER_PRBS_EN
      .io_prbs(1'b0),
`endif
      .io_in_valid(io_in_valid), .io_in_ready(rdy1), .io_in_bits(io_in_bits), .io_in_last(io_in_last),
      .io_out_valid(ov1), .io_out_bits_0(o1[0]), .io_out_bits_1(o1[1]), .io_out_bits_2(o1[2]),
      .io_out_bits_3(o1[3]), .io_underrun(un1));

   pam5_symbol_mapper #(.LEVEL(LEVEL), .SEED(33'h0)) u_dut0 (
      .clock(clock), .reset(reset), .io_en(io_en),
`ifdef PAM5_MAPPER_PRBS_EN
      .io_prbs(1'b0),
`endif
      .io_in_valid(io_in_valid), .io_in_ready(rdy0), .io_in_bits(io_in_bits), .io_in_last(io_in_last),
      .io_out_valid(ov0), .io_out_bits_0(o0[0]), .io_out_bits_1(o0[1]), .io_out_bits_2(o0[2]),
      .io_out_bits_3(o0[3]), .io_underrun(un0));

   function automatic logic [7:0] amp(input int s);
      return 8'(s * LEVEL);
   endfunction

   function automatic int gray_sym(input logic [1:0] b);
      case (b)
         2'b00:   return -2;
         2'b01:   return -1;
         2'b11:   return 1;
         default: return 2;
      endcase
   endfunction

   function automatic logic [32:0] lfsr_next(input logic [32:0] s);
      return {s[31:0], s[32] ^ s[12]};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic chk_lanes(input string tag, input logic [3:0][7:0] obs, input int a, input int b,
                            input int c, input int d);
      int v[4];
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++) chk($sformatf("%s_lane%0d", tag, i), obs[i], 8'(v[i]));
   endtask

   task automatic check_outputs();
      chk("valid_s1", 8'(ov1), 8'(e_valid));
      chk("valid_s0", 8'(ov0), 8'(e_valid));
      chk("underrun_s1", 8'(un1), 8'(e_under));
      chk("underrun_s0", 8'(un0), 8'(e_under));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("s1_lane%0d", i), o1[i], e1[i]);
         chk($sformatf("s0_lane%0d", i), o0[i], e0[i]);
      end
   endtask

   task automatic model_reset();
      sched.delete();
      m_scr1  = 33'h1;
      m_scr0  = 33'h0;
      e1      = '0;
      e0      = '0;
      e_valid = 1'b0;
      e_under = 1'b0;
   endtask

   // Reference: a queue of scheduled symbol kinds; an empty schedule means idle fill.
   task automatic model_step(input logic en, input logic valid, input logic [7:0] b, input logic last);
      kind_e      kd;
      logic [7:0] d1, d0;
      if (!en) begin
         sched.delete();
         e1      = '0;
         e0      = '0;
         e_valid = 1'b0;
         return;
      end
      e_valid = 1'b1;
      if (sched.size() == 0) begin
         for (int i = 0; i < 4; i++) begin
            e1[i] = amp(m_scr1[2*i] ? 2 : -2);
            e0[i] = amp(m_scr0[2*i] ? 2 : -2);
         end
         if (valid) begin
            sched.push_back(K_SSD);
            sched.push_back(K_SSD);
            sched.push_back(K_DATA);
         end
      end else begin
         kd = sched.pop_front();
         case (kd)
            K_SSD: for (int i = 0; i < 4; i++) begin e1[i] = amp(2); e0[i] = amp(2); end
            K_ESD: for (int i = 0; i < 4; i++) begin e1[i] = amp(-2); e0[i] = amp(-2); end
            default: begin
               if (valid) begin
                  d1 = b ^ m_scr1[7:0];
                  d0 = b ^ m_scr0[7:0];
                  for (int i = 0; i < 4; i++) begin
                     e1[i] = amp(gray_sym(d1[2*i +: 2]));
                     e0[i] = amp(gray_sym(d0[2*i +: 2]));
                  end
                  if (last) begin
                     sched.push_back(K_ESD);
                     sched.push_back(K_ESD);
                  end else begin
                     sched.push_back(K_DATA);
                  end
               end else begin
                  e1      = '0;
                  e0      = '0;
                  e_under = 1'b1;
                  sched.push_back(K_DATA);
               end
            end
         endcase
      end
      m_scr1 = lfsr_next(m_scr1);
      m_scr0 = lfsr_next(m_scr0);
   endtask

   // One clock: drive at the negedge, check ready, advance model, check registered outputs at next negedge.
   task automatic step(input logic en, input logic valid, input logic [7:0] b, input logic last);
      logic exp_rdy;
      io_en       = en;
      io_in_valid = valid;
      io_in_bits  = b;
      io_in_last  = last;
      #1;
      exp_rdy = en && (sched.size() > 0) && (sched[0] == K_DATA);
      chk("ready_s1", 8'(rdy1), 8'(exp_rdy));
      chk("ready_s0", 8'(rdy0), 8'(exp_rdy));
      model_step(en, valid, b, last);
      @(negedge clock);
      check_outputs();
   endtask

   task automatic drive_packet(input logic [7:0] bytes[$], input int drop_at, input int drop_len);
      int n;
      n = bytes.size();
      repeat (3) step(1'b1, 1'b1, bytes[0], n == 1);
      for (int i = 0; i < n; i++) begin
         if (i == drop_at) repeat (drop_len) step(1'b1, 1'b0, 8'h00, 1'b0);
         step(1'b1, 1'b1, bytes[i], i == n - 1);
      end
      repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      logic [7:0] pkt[$];
      int         n, drop_at, drop_len, gap;

      reset = 1'b1; io_en = 1'b0; io_in_valid = 1'b0; io_in_bits = 8'h00; io_in_last = 1'b0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      check_outputs();
      chk("reset_ready", 8'(rdy1), 8'd0);
      reset = 1'b0;

      // Idle fill from SEED=1.
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk_lanes("idle_e1", o1, 64, -64, -64, -64);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk_lanes("idle_e2", o1, -64, -64, -64, -64);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk_lanes("idle_e3", o1, -64, 64, -64, -64);
      chk("idle_valid", 8'(ov1), 8'd1);

      // Single-byte packet 0xB4, unscrambled instance.
      step(1'b1, 1'b1, 8'hB4, 1'b1);
      step(1'b1, 1'b1, 8'hB4, 1'b1);
      chk_lanes("b4_ssd1", o0, 64, 64, 64, 64);
      step(1'b1, 1'b1, 8'hB4, 1'b1);
      chk_lanes("b4_ssd2", o0, 64, 64, 64, 64);
      chk("b4_ready", 8'(rdy0), 8'd1);
      step(1'b1, 1'b1, 8'hB4, 1'b1);
      chk_lanes("b4_data", o0, -64, -32, 32, 64);
      chk("b4_ready_after", 8'(rdy0), 8'd0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk_lanes("b4_esd1", o0, -64, -64, -64, -64);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk_lanes("b4_esd2", o0, -64, -64, -64, -64);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk_lanes("b4_idle", o0, -64, -64, -64, -64);

      // Three-byte packet with valid held high.
      repeat (3) step(1'b1, 1'b1, 8'h00, 1'b0);
      step(1'b1, 1'b1, 8'h00, 1'b0);
      chk_lanes("p3_b0", o0, -64, -64, -64, -64);
      step(1'b1, 1'b1, 8'hFF, 1'b0);
      chk_lanes("p3_b1", o0, 32, 32, 32, 32);
      step(1'b1, 1'b1, 8'hAA, 1'b1);
      chk_lanes("p3_b2", o0, 64, 64, 64, 64);
      repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
      chk("p3_no_underrun", 8'(un0), 8'd0);

      // Valid dropped for two cycles mid-packet.
      pkt = '{8'h12, 8'h34, 8'h56};
      drive_packet(pkt, 1, 2);
      chk("underrun_set", 8'(un1), 8'd1);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk("underrun_sticky", 8'(un1), 8'd1);

      // Asynchronous reset between edges while in DATA.
      repeat (4) step(1'b1, 1'b1, 8'h5A, 1'b0);
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk_lanes("arst_s1", o1, 0, 0, 0, 0);
      chk("arst_valid", 8'(ov1), 8'd0);
      chk("arst_ready", 8'(rdy1), 8'd0);
      chk("arst_underrun", 8'(un1), 8'd0);
      @(negedge clock);
      reset = 1'b0;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk_lanes("arst_restart", o1, 64, -64, -64, -64);
      step(1'b1, 1'b0, 8'h00, 1'b0);

      // Enable dropped during SSD2, then resumed from IDLE with held scrambler.
      step(1'b1, 1'b1, 8'h77, 1'b0);
      step(1'b1, 1'b1, 8'h77, 1'b0);
      step(1'b0, 1'b1, 8'h77, 1'b0);
      chk("en_drop_valid", 8'(ov1), 8'd0);
      chk_lanes("en_drop_s1", o1, 0, 0, 0, 0);
      repeat (2) step(1'b1, 1'b0, 8'h00, 1'b0);

      // Randomized packets, underruns and enable gaps.
      for (int p = 0; p < 25; p++) begin
         n = int'($urandom_range(1, 6));
         pkt.delete();
         for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
         drop_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         drop_len = int'($urandom_range(1, 3));
         drive_packet(pkt, drop_at, drop_len);
         gap = int'($urandom_range(0, 3));
         repeat (gap) step($urandom_range(0, 7) != 0, 1'b0, 8'($urandom), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
